// File: rtl/serial_bit_deserializer.sv
// -----------------------------------------------------------------------------
// serial_bit_deserializer
//   Collects a 1-bit serial stream into DATA_WIDTH-bit words and presents each
//   completed word on a valid/ready output port.
//
//   Parameters
//     DATA_WIDTH : word width in bits (>= 2)
//     MSB_FIRST  : 1 -> first accepted bit lands in dout[DATA_WIDTH-1]
//                  0 -> first accepted bit lands in dout[0]
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high reset
//     flush       synchronous; discards the partially assembled word
//     din         serial data bit
//     din_valid   din is valid this cycle
//     din_ready   block can accept din this cycle (combinational)
//     dout        assembled parallel word (registered)
//     dout_valid  dout holds an unconsumed word
//     dout_ready  downstream accepts dout this cycle
//     bit_cnt     bits of the current partial word accepted so far
// -----------------------------------------------------------------------------
module serial_bit_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            din,
  input  logic                            din_valid,
  output logic                            din_ready,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // The partial word never holds more than DATA_WIDTH-1 bits: the final bit
  // goes straight into dout together with the partial word.
  logic [DATA_WIDTH-2:0] shift_reg, shift_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic                  valid_reg, valid_next;

  logic                  last_bit;
  logic                  accept;
  logic [DATA_WIDTH-1:0] shifted;

  assign last_bit  = (cnt_reg == LAST);
  // Only the word-completing bit has to wait for a free output register.
  assign din_ready = !(last_bit && valid_reg && !dout_ready);
  assign accept    = din_valid && din_ready && !flush;

  // Partial word extended by the incoming bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_reg, din};
    end else begin : g_lsb_first
      assign shifted = {din, shift_reg};
    end
  endgenerate

  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    valid_next = valid_reg;

    if (valid_reg && dout_ready) begin
      valid_next = 1'b0;
    end

    if (flush) begin
      shift_next = '0;
      cnt_next   = '0;
    end else if (accept) begin
      if (last_bit) begin
        // A completion on the same edge as a transfer overrides the clear.
        shift_next = '0;
        cnt_next   = '0;
        dout_next  = shifted;
        valid_next = 1'b1;
      end else begin
        if (MSB_FIRST) begin
          shift_next = shifted[DATA_WIDTH-2:0];
        end else begin
          shift_next = shifted[DATA_WIDTH-1:1];
        end
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = valid_reg;
  assign bit_cnt    = cnt_reg;

endmodule

// File: tb/tb_serial_bit_deserializer.sv
module tb_serial_bit_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 8-bit instances (MSB-first and LSB-first).
  logic       reset, flush, din, din_valid, dout_ready;
  logic       a_ready, b_ready, a_valid, b_valid;
  logic [7:0] a_dout, b_dout;
  logic [3:0] a_cnt, b_cnt;

  // 32-bit instance.
  logic        c_din, c_din_valid, c_flush, c_rdy;
  logic        c_ready, c_valid;
  logic [31:0] c_dout;
  logic [5:0]  c_cnt;

  serial_bit_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(a_ready), .dout(a_dout), .dout_valid(a_valid),
    .dout_ready(dout_ready), .bit_cnt(a_cnt));

  serial_bit_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(b_ready), .dout(b_dout), .dout_valid(b_valid),
    .dout_ready(dout_ready), .bit_cnt(b_cnt));

  serial_bit_deserializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .din(c_din), .din_valid(c_din_valid),
    .din_ready(c_ready), .dout(c_dout), .dout_valid(c_valid),
    .dout_ready(c_rdy), .bit_cnt(c_cnt));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Reference model of the 8-bit instances plus the output scoreboard.
  int         m_cnt = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_word = 8'h00;
  logic [7:0] sbq[$];
  int         pushed = 0;
  int         popped = 0;

  task automatic drive(input bit v, input bit d, input bit r, input bit f);
    @(negedge clk);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    flush      = f;
    #1;
  endtask

  task automatic model_step();
    bit         mr;
    logic [7:0] e;
    mr = !(m_cnt == 7 && m_valid && !dout_ready);
    chk("din_ready", {31'd0, a_ready}, {31'd0, mr});
    chk("b_din_ready", {31'd0, b_ready}, {31'd0, mr});
    chk("bit_cnt", {28'd0, a_cnt}, m_cnt);
    chk("dout_valid", {31'd0, a_valid}, {31'd0, m_valid});
    chk("b_dout_valid", {31'd0, b_valid}, {31'd0, m_valid});
    if (m_valid && dout_ready) begin
      chk("sb_has_word", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("dout", {24'd0, a_dout}, {24'd0, e});
        chk("dout_lsb_first", {24'd0, b_dout}, {24'd0, rev8(e)});
        popped++;
      end
      m_valid = 1'b0;
    end
    if (flush) begin
      m_cnt = 0;
    end else if (din_valid && mr) begin
      m_word = {m_word[6:0], din};
      if (m_cnt == 7) begin
        sbq.push_back(m_word);
        pushed++;
        m_valid = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input bit v, input bit d, input bit r, input bit f);
    drive(v, d, r, f);
    model_step();
  endtask

  task automatic feed8(input logic [7:0] w, input bit r);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
  endtask

  typedef struct {
    bit         v, d, r, f;
    bit         er;
    int         ec;
    bit         ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input bit d, input bit r, input bit er,
                     input int ec, input bit ev, input logic [7:0] ed);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.f = 1'b0;
    x.er = er; x.ec = ec; x.ev = ev; x.ed = ed;
    tbl.push_back(x);
  endtask

  initial begin
    logic [7:0]  wb2;
    logic [31:0] wc;
    int          p0, q0, cyc;

    wb2 = 8'hB2;
    wc  = 32'hDEADBEEF;

    // Basic word with dout_ready=1: 1-cycle valid pulse after the 8th bit.
    for (int i = 0; i < 8; i++) add(1'b1, wb2[7-i], 1'b1, 1'b1, i, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 8'hB2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'hB2);
    // Backpressure: B2 held, FF streams in, last bit stalls until transfer.
    for (int i = 0; i < 8; i++) add(1'b1, wb2[7-i], 1'b0, 1'b1, i, 1'b0, 8'hB2);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b1, 1'b0, 1'b1, i, 1'b1, 8'hB2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b1, 8'hB2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b1, 8'hB2);
    add(1'b1, 1'b1, 1'b1, 1'b1, 7, 1'b1, 8'hB2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 8'hFF);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 8'hFF);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'hFF);

    reset = 1'b1; flush = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    c_din = 1'b0; c_din_valid = 1'b0; c_flush = 1'b0; c_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_dout", {24'd0, a_dout}, 32'd0);
    chk("reset_valid", {31'd0, a_valid}, 32'd0);
    chk("reset_cnt", {28'd0, a_cnt}, 32'd0);
    chk("reset_ready", {31'd0, a_ready}, 32'd1);
    chk("reset_c_dout", c_dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 32-bit word DEADBEEF.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      c_din_valid = 1'b1;
      c_din = wc[31-i];
      #1;
      chk("c_bit_cnt", {26'd0, c_cnt}, i);
      chk("c_valid_low", {31'd0, c_valid}, 32'd0);
    end
    @(negedge clk);
    c_din_valid = 1'b0;
    #1;
    chk("c_dout", c_dout, 32'hDEADBEEF);
    chk("c_valid", {31'd0, c_valid}, 32'd1);
    chk("c_bit_cnt_wrap", {26'd0, c_cnt}, 32'd0);
    @(negedge clk); #1;
    chk("c_valid_pulse", {31'd0, c_valid}, 32'd0);

    // Table-driven basic and backpressure vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      chk($sformatf("tbl%0d_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_cnt", i), {28'd0, a_cnt}, tbl[i].ec);
      chk($sformatf("tbl%0d_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_dout", i), {24'd0, a_dout}, {24'd0, tbl[i].ed});
      if (i == 8) begin
        chk("lsb_first_4D", {24'd0, b_dout}, 32'h4D);
        chk("reverser_4D", {24'd0, rev8(a_dout)}, 32'h4D);
      end
      model_step();
    end

    // Flush after 5 bits, then a fresh 3C.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    feed8(8'h3C, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_dout_3C", {24'd0, a_dout}, 32'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Flush while a word is held.
    feed8(8'h5A, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_after_flush_dout", {24'd0, a_dout}, 32'h5A);
    chk("held_after_flush_valid", {31'd0, a_valid}, 32'd1);
    model_step();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Random gaps and backpressure over 100 words.
    p0 = pushed; q0 = popped; cyc = 0;
    while ((pushed - p0) < 100 && cyc < 6000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cyc++;
    end
    cyc = 0;
    while ((m_valid || sbq.size() != 0) && cyc < 20) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      cyc++;
    end
    chk("random_pushed", pushed - p0, 32'd100);
    chk("random_popped", popped - q0, 32'd100);

    // Asynchronous reset mid-word with a held word.
    feed8(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_dout", {24'd0, a_dout}, 32'd0);
    chk("async_reset_valid", {31'd0, a_valid}, 32'd0);
    chk("async_reset_cnt", {28'd0, a_cnt}, 32'd0);
    chk("async_reset_b_valid", {31'd0, b_valid}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    m_cnt = 0; m_valid = 1'b0; sbq.delete();
    feed8(8'h96, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_reset_dout", {24'd0, a_dout}, 32'h96);
    model_step();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", {31'd0, sbq.size() == 0}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
